// File: rtl/axi4_burst_mem_slave.sv
// AXI4 burst slave backed by a register-array memory. The write and read FSMs run independently,
// drive only registered outputs, support FIXED/INCR/WRAP addressing and report SLVERR.
module axi4_burst_mem_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_MEM_DEPTH        = 1024
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [7:0]                        S_AXI_AWLEN,
    input  logic [1:0]                        S_AXI_AWBURST,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WLAST,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_BID,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [7:0]                        S_AXI_ARLEN,
    input  logic [1:0]                        S_AXI_ARBURST,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RLAST,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY
);
    localparam int DATA_W  = C_S_AXI_DATA_WIDTH;
    localparam int ADDR_W  = C_S_AXI_ADDR_WIDTH;
    localparam int ID_W    = C_S_AXI_ID_WIDTH;
    localparam int BYTES   = DATA_W / 8;
    localparam int BYTE_SH = $clog2(BYTES);
    localparam int IDX_W   = $clog2(C_MEM_DEPTH);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [DATA_W-1:0] mem [C_MEM_DEPTH];

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    function automatic logic burst_err(input logic [1:0] burst, input logic [7:0] len);
        return (burst == BURST_RSVD) || ((burst == BURST_WRAP) && !wrap_len_ok(len));
    endfunction

    // An illegal WRAP length falls back to INCR stepping.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [7:0] len,
                                                    input logic [1:0] burst);
        logic [ADDR_W-1:0] inc;
        logic [ADDR_W-1:0] mask;
        inc  = a + ADDR_W'(BYTES);
        mask = ((ADDR_W'(len) + ADDR_W'(1)) << BYTE_SH) - ADDR_W'(1);
        if (burst == BURST_FIXED)
            return a;
        if ((burst == BURST_WRAP) && wrap_len_ok(len))
            return (a & ~mask) | (inc & mask);
        return inc;
    endfunction

    function automatic logic [ADDR_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return a >> BYTE_SH;
    endfunction

    // Write channel state
    w_state_t            w_state_q, w_state_d;
    logic                awready_q, awready_d;
    logic                wready_q, wready_d;
    logic                bvalid_q, bvalid_d;
    logic [1:0]          bresp_q, bresp_d;
    logic [ID_W-1:0]     aw_id_q, aw_id_d;
    logic [ADDR_W-1:0]   aw_addr_q, aw_addr_d;
    logic [7:0]          aw_len_q, aw_len_d;
    logic [1:0]          aw_burst_q, aw_burst_d;
    logic [7:0]          w_cnt_q, w_cnt_d;
    logic                w_err_q, w_err_d;
    logic [ADDR_W-1:0]   w_idx;
    logic                w_in_rng;
    logic                w_last;
    logic                w_beat_err;
    logic                mem_we;

    always_comb begin
        w_state_d  = w_state_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        aw_id_d    = aw_id_q;
        aw_addr_d  = aw_addr_q;
        aw_len_d   = aw_len_q;
        aw_burst_d = aw_burst_q;
        w_cnt_d    = w_cnt_q;
        w_err_d    = w_err_q;
        mem_we     = 1'b0;
        w_idx      = word_idx(aw_addr_q);
        w_in_rng   = (w_idx < ADDR_W'(C_MEM_DEPTH));
        w_last     = (w_cnt_q == aw_len_q);
        w_beat_err = !w_in_rng || (S_AXI_WLAST != w_last);
        case (w_state_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (S_AXI_AWVALID && awready_q) begin
                    aw_id_d    = S_AXI_AWID;
                    aw_addr_d  = S_AXI_AWADDR;
                    aw_len_d   = S_AXI_AWLEN;
                    aw_burst_d = S_AXI_AWBURST;
                    w_cnt_d    = 8'd0;
                    w_err_d    = burst_err(S_AXI_AWBURST, S_AXI_AWLEN);
                    awready_d  = 1'b0;
                    wready_d   = 1'b1;
                    w_state_d  = W_DATA;
                end
            end
            W_DATA: begin
                if (S_AXI_WVALID && wready_q) begin
                    mem_we    = w_in_rng && (aw_burst_q != BURST_RSVD);
                    aw_addr_d = next_addr(aw_addr_q, aw_len_q, aw_burst_q);
                    w_cnt_d   = w_cnt_q + 8'd1;
                    w_err_d   = w_err_q || w_beat_err;
                    // Burst length is set by AWLEN alone; a wrong WLAST only taints the response.
                    if (w_last) begin
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bresp_d   = (w_err_q || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY && bvalid_q) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_state_q  <= W_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            aw_id_q    <= '0;
            aw_addr_q  <= '0;
            aw_len_q   <= 8'd0;
            aw_burst_q <= 2'b00;
            w_cnt_q    <= 8'd0;
            w_err_q    <= 1'b0;
        end else begin
            w_state_q  <= w_state_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            aw_id_q    <= aw_id_d;
            aw_addr_q  <= aw_addr_d;
            aw_len_q   <= aw_len_d;
            aw_burst_q <= aw_burst_d;
            w_cnt_q    <= w_cnt_d;
            w_err_q    <= w_err_d;
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge S_AXI_ACLK) begin
        if (mem_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (S_AXI_WSTRB[b])
                    mem[w_idx[IDX_W-1:0]][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
            end
        end
    end

    // Read channel state
    r_state_t            r_state_q, r_state_d;
    logic                arready_q, arready_d;
    logic                rvalid_q, rvalid_d;
    logic                rlast_q, rlast_d;
    logic [1:0]          rresp_q, rresp_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [ID_W-1:0]     ar_id_q, ar_id_d;
    logic [ADDR_W-1:0]   r_addr_q, r_addr_d;
    logic [7:0]          ar_len_q, ar_len_d;
    logic [1:0]          ar_burst_q, ar_burst_d;
    logic [7:0]          r_cnt_q, r_cnt_d;
    logic                r_load;
    logic [ADDR_W-1:0]   ld_addr;
    logic [7:0]          ld_len;
    logic [1:0]          ld_burst;
    logic [ADDR_W-1:0]   ld_idx;
    logic                ld_in_rng;

    always_comb begin
        r_state_d  = r_state_q;
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        rlast_d    = rlast_q;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;
        ar_id_d    = ar_id_q;
        r_addr_d   = r_addr_q;
        ar_len_d   = ar_len_q;
        ar_burst_d = ar_burst_q;
        r_cnt_d    = r_cnt_q;
        r_load     = 1'b0;
        ld_addr    = r_addr_q;
        ld_len     = ar_len_q;
        ld_burst   = ar_burst_q;
        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (S_AXI_ARVALID && arready_q) begin
                    ar_id_d    = S_AXI_ARID;
                    ar_len_d   = S_AXI_ARLEN;
                    ar_burst_d = S_AXI_ARBURST;
                    r_cnt_d    = 8'd0;
                    r_load     = 1'b1;
                    ld_addr    = S_AXI_ARADDR;
                    ld_len     = S_AXI_ARLEN;
                    ld_burst   = S_AXI_ARBURST;
                    rlast_d    = (S_AXI_ARLEN == 8'd0);
                    arready_d  = 1'b0;
                    rvalid_d   = 1'b1;
                    r_state_d  = R_DATA;
                end
            end
            R_DATA: begin
                if (rvalid_q && S_AXI_RREADY) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        r_state_d = R_IDLE;
                    end else begin
                        r_load  = 1'b1;
                        r_cnt_d = r_cnt_q + 8'd1;
                        rlast_d = ((r_cnt_q + 8'd1) == ar_len_q);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        // r_addr always holds the address of the next beat to fetch.
        ld_idx    = word_idx(ld_addr);
        ld_in_rng = (ld_idx < ADDR_W'(C_MEM_DEPTH));
        if (r_load) begin
            rdata_d  = (ld_in_rng && (ld_burst != BURST_RSVD)) ? mem[ld_idx[IDX_W-1:0]] : '0;
            rresp_d  = (!ld_in_rng || burst_err(ld_burst, ld_len)) ? RESP_SLVERR : RESP_OKAY;
            r_addr_d = next_addr(ld_addr, ld_len, ld_burst);
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state_q  <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
            ar_id_q    <= '0;
            r_addr_q   <= '0;
            ar_len_q   <= 8'd0;
            ar_burst_q <= 2'b00;
            r_cnt_q    <= 8'd0;
        end else begin
            r_state_q  <= r_state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rlast_q    <= rlast_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            ar_id_q    <= ar_id_d;
            r_addr_q   <= r_addr_d;
            ar_len_q   <= ar_len_d;
            ar_burst_q <= ar_burst_d;
            r_cnt_q    <= r_cnt_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_BID     = aw_id_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RLAST   = rlast_q;
    assign S_AXI_RID     = ar_id_q;

endmodule
